// File: rtl/rnbip_pkg.sv
// rnbip_pkg: shared definitions for the RNBIP-2 front end.
//   - pc_sel encodings used by stage 3 for PC redirects
//   - instruction segment layout: opcode [15:8], operand [7:0]
//   - fetch FSM state type
package rnbip_pkg;

   localparam logic [1:0] PC_SEL_RSV = 2'b00;  // bubble-only flush, PC unchanged
   localparam logic [1:0] PC_SEL_REL = 2'b01;
   localparam logic [1:0] PC_SEL_ABS = 2'b11;
   localparam logic [1:0] PC_SEL_RET = 2'b10;

   localparam logic [7:0] NOP_OPCODE = 8'h00;

   localparam int SEG_OPC_MSB = 15;
   localparam int SEG_OPC_LSB = 8;
   localparam int SEG_OPR_MSB = 7;
   localparam int SEG_OPR_LSB = 0;

   // ST_IDLE only exists while reset is held and for the first edge after
   // release, so no request is issued before the pipe is live.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_FETCH  = 2'b01,
      ST_WAIT   = 2'b10,
      ST_BUBBLE = 2'b11
   } fetch_state_e;

   function automatic logic [15:0] mk_seg(input logic [7:0] opc, input logic [7:0] opr);
      logic [15:0] s;
      s = '0;
      s[SEG_OPC_MSB:SEG_OPC_LSB] = opc;
      s[SEG_OPR_MSB:SEG_OPR_LSB] = opr;
      return s;
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: redirect target select for the fetch unit.
//   pc_sel_i     : {S11,S10} redirect kind
//   or2_i        : relative offset (two's complement) or absolute target
//   npc_in_i     : NPC of the stage-3 instruction (base for relative)
//   stack_data_i : return address from the stack
//   pc_i         : current fetch PC (reserved encoding keeps it)
//   target_o     : next PC after the redirect
module pc_next_mux
   import rnbip_pkg::*;
(
   input  logic [1:0] pc_sel_i,
   input  logic [7:0] or2_i,
   input  logic [7:0] npc_in_i,
   input  logic [7:0] stack_data_i,
   input  logic [7:0] pc_i,
   output logic [7:0] target_o
);

   // 8-bit add: a negative offset in or2 wraps naturally mod 256.
   logic [7:0] rel_tgt;
   assign rel_tgt = npc_in_i + or2_i;

   always_comb begin
      target_o = pc_i;
      unique case (pc_sel_i)
         PC_SEL_REL: target_o = rel_tgt;
         PC_SEL_ABS: target_o = or2_i;
         PC_SEL_RET: target_o = stack_data_i;
         PC_SEL_RSV: target_o = pc_i;
         default:    target_o = pc_i;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the RNBIP-2 pipeline.
// Owns the PC and the instruction-memory handshake, hands {opcode,operand}
// plus its NPC to CCG1, and applies stage-3 redirects with optional bubbles.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   imem_req, imem_addr        fetch request and address (current PC)
//   imem_rdata, imem_ready     returned word, valid when ready=1
//   stall_i                    hold fetch and output registers
//   l_pc, pc_sel, or2, npc_in,
//   stack_data                 stage-3 redirect controls and operands
//   segment, pc_out, seg_valid instruction, its NPC, and validity to CCG1
//   flush_o                    combinational pulse in the redirect cycle
module fetch_unit
   import rnbip_pkg::*;
#(
   parameter logic [7:0]  RESET_PC = 8'h00,
   parameter int unsigned BUBBLES  = 0,
   parameter logic [15:0] NOP_SEG  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall_i,
   input  logic        l_pc,
   input  logic [1:0]  pc_sel,
   input  logic [7:0]  or2,
   input  logic [7:0]  npc_in,
   input  logic [7:0]  stack_data,
   output logic [15:0] segment,
   output logic [7:0]  pc_out,
   output logic        seg_valid,
   output logic        flush_o
);

   localparam logic [1:0] BUB_CNT = 2'(BUBBLES);

   fetch_state_e st_q, st_d;
   logic [7:0]   pc_q, pc_d;
   logic [15:0]  seg_q, seg_d;
   logic [7:0]   pco_q, pco_d;
   logic         vld_q, vld_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [7:0]   target;
   logic [7:0]   pc_inc;
   logic         fetching;

   pc_next_mux u_pc_next_mux (
      .pc_sel_i    (pc_sel),
      .or2_i       (or2),
      .npc_in_i    (npc_in),
      .stack_data_i(stack_data),
      .pc_i        (pc_q),
      .target_o    (target)
   );

   assign pc_inc   = pc_q + 8'd1;  // wraps FF->00 silently
   assign fetching = (st_q == ST_FETCH) || (st_q == ST_WAIT);

   assign imem_req  = fetching && !stall_i;
   assign imem_addr = pc_q;
   assign segment   = seg_q;
   assign pc_out    = pco_q;
   assign seg_valid = vld_q;
   assign flush_o   = l_pc;

   always_comb begin
      st_d  = st_q;
      pc_d  = pc_q;
      seg_d = seg_q;
      pco_d = pco_q;
      vld_d = vld_q;
      cnt_d = cnt_q;
      if (l_pc) begin
         // Redirect beats stall, a returning word, WAIT and BUBBLE alike.
         pc_d  = target;
         seg_d = NOP_SEG;
         vld_d = 1'b0;
         if (BUBBLES > 0) begin
            cnt_d = BUB_CNT;
            st_d  = ST_BUBBLE;
         end else begin
            st_d  = ST_FETCH;
         end
      end else if (!stall_i) begin
         unique case (st_q)
            ST_IDLE: st_d = ST_FETCH;
            ST_FETCH, ST_WAIT: begin
               if (imem_ready) begin
                  seg_d = imem_rdata;
                  pco_d = pc_inc;
                  vld_d = 1'b1;
                  pc_d  = pc_inc;
                  st_d  = ST_FETCH;
               end else begin
                  seg_d = NOP_SEG;
                  vld_d = 1'b0;
                  st_d  = ST_WAIT;
               end
            end
            ST_BUBBLE: begin
               seg_d = NOP_SEG;
               vld_d = 1'b0;
               cnt_d = cnt_q - 2'd1;
               // <=1 also guards a zero count from ever sticking here
               if (cnt_q <= 2'd1) begin
                  cnt_d = 2'd0;
                  st_d  = ST_FETCH;
               end
            end
            default: st_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= ST_IDLE;
         pc_q  <= RESET_PC;
         seg_q <= NOP_SEG;
         pco_q <= 8'h00;
         vld_q <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         st_q  <= st_d;
         pc_q  <= pc_d;
         seg_q <= seg_d;
         pco_q <= pco_d;
         vld_q <= vld_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 3-stage RNBIP-2 pipeline; sits directly upstream of CCG1.
- Owns the program counter and the instruction-memory handshake.
- Delivers the 16-bit segment {opcode[15:8], operand[7:0]} plus the NPC to CCG1 each cycle.
- Applies PC redirects from stage 3 (jump/call/return); on each redirect it injects NOP bubbles and pulses a flush to the control pipe.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.
BUBBLES, 0, extra NOP cycles issued after the redirect cycle (range 0-3).
NOP_SEG, 16'h0000, segment driven when no valid instruction is available.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_req  out  1  fetch request
imem_addr  out  8  fetch address (current PC)
imem_rdata  in  16  instruction word, valid when imem_ready=1
imem_ready  in  1  memory accepts request and returns data this cycle
stall_i  in  1  hold fetch and output registers
l_pc  in  1  stage-3 PC load (L_PC)
pc_sel  in  2  {S11,S10}: 01 relative, 11 absolute, 10 stack return, 00 reserved
or2  in  8  operand from stage 3 (offset or absolute target)
npc_in  in  8  NPC of the stage-3 instruction
stack_data  in  8  return address popped from SP/DM
segment  out  16  instruction to CCG1
pc_out  out  8  NPC of segment (fetch address + 1), to CCG1 PC_in
seg_valid  out  1  segment holds a real fetched instruction
flush_o  out  1  one-cycle pulse; CCG1/CCG2 squash to NOP on the next edge

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, segment=NOP_SEG, pc_out=8'h00, seg_valid=0, flush_o=0, imem_req=0, bubble counter=0.
  - FSM enters FETCH on the first edge after release.
- FSM states: FETCH, WAIT, BUBBLE.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_ready=1: segment<=imem_rdata, pc_out<=pc+1, seg_valid<=1, pc<=pc+1; stay in FETCH. Latency: address to segment is 1 edge.
  - If imem_ready=0: go to WAIT; segment<=NOP_SEG, seg_valid<=0.
- WAIT:
  - Same address, imem_req held at 1.
  - imem_ready=1 completes the fetch exactly as in FETCH and returns to FETCH.
  - Otherwise keep emitting NOP.
- stall_i=1 (no l_pc):
  - imem_req=0; pc, segment, pc_out, seg_valid and FSM state are held.
  - Any imem_ready during a stall is ignored.
- Redirect (l_pc=1) has priority over stall_i, imem_ready and WAIT. Target by pc_sel:
  - 01: npc_in+or2, 8-bit modular add (or2 as two's complement, wraps mod 256).
  - 11: or2.
  - 10: stack_data.
  - 00: pc+0, treated as a bubble-only flush.
- On the redirect edge:
  - pc<=target; segment<=NOP_SEG, seg_valid<=0.
  - Any word returned that cycle is discarded.
  - flush_o=1 combinationally in the l_pc cycle.
  - If BUBBLES>0: counter<=BUBBLES, go to BUBBLE; else go to FETCH.
- BUBBLE:
  - imem_req=0, NOP output, counter decrements each edge; FETCH when the counter reaches 1.
  - A new l_pc in BUBBLE restarts the redirect.
- PC wrap: 8'hFF+1 = 8'h00, with no error flag.
- Reset asserted mid-WAIT or mid-BUBBLE: immediate return to reset values; no pending request survives.

Decomposition:
- Shared package rnbip_pkg holds:
  - PC_SEL_REL=2'b01, PC_SEL_ABS=2'b11, PC_SEL_RET=2'b10.
  - NOP opcode 8'h00.
  - The segment field slices (opcode [15:8], operand [7:0]).
  - The fetch FSM state enum.
- One natural sub-module: pc_next_mux, a combinational target select plus modular adder.

Test Plan:
- Reset release, RESET_PC=8'h00, memory always ready, mem[0]=16'h5A3C, mem[1]=16'h8105 -> imem_addr 00,01,02 on successive cycles; segment 5A3C then 8105; pc_out 01 then 02; seg_valid=1 from the first edge.
- imem_ready low for 3 cycles at addr 8'h04 -> imem_addr stays 04 with req=1; segment=0000, seg_valid=0 for 3 cycles; then mem[4] appears with pc_out=05.
- l_pc=1, pc_sel=01, npc_in=8'hF0, or2=8'h20 -> flush_o=1 that cycle; next imem_addr=8'h10 (wrap); segment=0000 on the redirect edge.
- l_pc=1, pc_sel=10, stack_data=8'h37, coincident with stall_i=1 and imem_ready=1 -> redirect wins; next imem_addr=37; the returned word is discarded.
- BUBBLES=2, absolute jump or2=8'h80 -> exactly 3 NOP cycles with seg_valid=0 (redirect edge plus 2), imem_req=0 during bubbles, then fetch at 80.
- rst_n pulled low mid-WAIT at addr 8'h22 -> outputs clear asynchronously; after release fetch restarts at RESET_PC.
